// File: rtl/game_flow_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : game_flow_sequencer_if                                           |
// | Brief   : Bundles the player, level and VGA signals of the game sequencer. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface game_flow_sequencer_if #(
  parameter int NUM_LEVELS  = 2,
  parameter int NUM_LIVES   = 3,
  parameter int COLOR_WIDTH = 4,
  parameter int LED_WIDTH   = 10
) ();
  localparam int LVL_W   = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int LIVES_W = $clog2(NUM_LIVES + 1);
  localparam int RGB_W   = 3 * COLOR_WIDTH;

  logic                        start_button;
  logic                        frame_tick;
  logic                        display_enable;
  logic [NUM_LEVELS-1:0]       level_win;
  logic [NUM_LEVELS-1:0]       level_lose;
  logic [NUM_LEVELS*RGB_W-1:0] level_rgb;
  logic [RGB_W-1:0]            start_rgb;
  logic [RGB_W-1:0]            win_rgb;
  logic [RGB_W-1:0]            over_rgb;
  logic [NUM_LEVELS-1:0]       level_enable;
  logic [NUM_LEVELS-1:0]       level_reset;
  logic [COLOR_WIDTH-1:0]      vga_red;
  logic [COLOR_WIDTH-1:0]      vga_green;
  logic [COLOR_WIDTH-1:0]      vga_blue;
  logic [LVL_W-1:0]            current_level;
  logic [LIVES_W-1:0]          lives;
  logic [LED_WIDTH-1:0]        leds;

  modport master (
    output start_button, frame_tick, display_enable, level_win, level_lose,
           level_rgb, start_rgb, win_rgb, over_rgb,
    input  level_enable, level_reset, vga_red, vga_green, vga_blue,
           current_level, lives, leds
  );

  modport slave (
    input  start_button, frame_tick, display_enable, level_win, level_lose,
           level_rgb, start_rgb, win_rgb, over_rgb,
    output level_enable, level_reset, vga_red, vga_green, vga_blue,
           current_level, lives, leds
  );
endinterface
`default_nettype wire

// File: rtl/game_flow_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : game_flow_sequencer                                              |
// | Brief   : Game-flow FSM: levels, lives, level enables/resets, VGA colour.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module game_flow_sequencer #(
  parameter int NUM_LEVELS         = 2,
  parameter int NUM_LIVES          = 3,
  parameter int COLOR_WIDTH        = 4,
  parameter int SCREEN_HOLD_FRAMES = 120,
  parameter int LED_WIDTH          = 10
) (
  input  wire logic            vga_clock,
  input  wire logic            reset,
  game_flow_sequencer_if.slave bus
);
  localparam int LVL_W   = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int LIVES_W = $clog2(NUM_LIVES + 1);
  localparam int RGB_W   = 3 * COLOR_WIDTH;
  localparam int HOLD_W  = $clog2(SCREEN_HOLD_FRAMES + 2);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_INTER = 3'd1,
    S_PLAY  = 3'd2,
    S_WIN   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LVL_W-1:0]   r_level;
  logic [LVL_W-1:0]   w_level_nxt;
  logic [LIVES_W-1:0] r_lives;
  logic [LIVES_W-1:0] w_lives_nxt;
  logic [HOLD_W-1:0]  r_hold;
  logic               r_btn_prev;
  logic [RGB_W-1:0]   r_rgb;
  logic [RGB_W-1:0]   w_sel_rgb;
  logic [RGB_W-1:0]   w_lvl_rgb [NUM_LEVELS];
  logic               w_press;
  logic               w_win;
  logic               w_lose;
  logic               w_last;

  // Button is active-low: a press is the released->pressed transition only.
  assign w_press = r_btn_prev & ~bus.start_button;
  assign w_win   = bus.level_win[r_level];
  assign w_lose  = bus.level_lose[r_level];
  assign w_last  = (r_level == LVL_W'(NUM_LEVELS - 1));

  for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_level
    assign w_lvl_rgb[i]        = bus.level_rgb[i*RGB_W +: RGB_W];
    assign bus.level_enable[i] = (r_state == S_PLAY) && (r_level == LVL_W'(i));
    assign bus.level_reset[i]  = !((r_state == S_PLAY) && (r_level == LVL_W'(i)));
  end

  for (genvar i = 0; i < LED_WIDTH; i++) begin : g_leds
    assign bus.leds[i] = (int'(r_lives) > i);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_lives_nxt = r_lives;
    w_sel_rgb   = '0;
    case (r_state)
      S_START: begin
        w_sel_rgb = bus.start_rgb;
        if (w_press) begin
          w_state_nxt = S_INTER;
          w_level_nxt = '0;
          w_lives_nxt = LIVES_W'(NUM_LIVES);
        end
      end
      S_INTER: begin
        if (r_hold >= HOLD_W'(SCREEN_HOLD_FRAMES)) w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        w_sel_rgb = w_lvl_rgb[r_level];
        if (w_win) begin
          if (w_last) begin
            w_state_nxt = S_WIN;
          end else begin
            w_state_nxt = S_INTER;
            w_level_nxt = r_level + LVL_W'(1);
          end
        end else if (w_lose) begin
          if (r_lives > LIVES_W'(1)) begin
            w_state_nxt = S_INTER;
            w_lives_nxt = r_lives - LIVES_W'(1);
          end else begin
            w_state_nxt = S_OVER;
            w_lives_nxt = '0;
          end
        end
      end
      S_WIN, S_OVER: begin
        w_sel_rgb = (r_state == S_WIN) ? bus.win_rgb : bus.over_rgb;
        if (w_press) begin
          w_state_nxt = S_START;
          w_level_nxt = '0;
          w_lives_nxt = LIVES_W'(NUM_LIVES);
        end
      end
      default: w_state_nxt = S_START;
    endcase
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      r_state    <= S_START;
      r_level    <= '0;
      r_lives    <= LIVES_W'(NUM_LIVES);
      r_hold     <= '0;
      r_btn_prev <= 1'b0;
      r_rgb      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_lives    <= w_lives_nxt;
      r_btn_prev <= bus.start_button;
      r_rgb      <= bus.display_enable ? w_sel_rgb : '0;
      // Counter is zero on every INTER entry because any other state clears it.
      if (r_state != S_INTER)  r_hold <= '0;
      else if (bus.frame_tick) r_hold <= r_hold + HOLD_W'(1);
    end
  end

  assign bus.vga_red       = r_rgb[3*COLOR_WIDTH-1:2*COLOR_WIDTH];
  assign bus.vga_green     = r_rgb[2*COLOR_WIDTH-1:COLOR_WIDTH];
  assign bus.vga_blue      = r_rgb[COLOR_WIDTH-1:0];
  assign bus.current_level = r_level;
  assign bus.lives         = r_lives;
endmodule
`default_nettype wire

// File: tb/tb_game_flow_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_game_flow_sequencer                                           |
// | Brief   : Directed self-checking bench for game_flow_sequencer.            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_game_flow_sequencer;
  localparam int NL = 2;
  localparam int CW = 4;

  localparam logic [11:0] C_START = 12'h123;
  localparam logic [11:0] C_WIN   = 12'h456;
  localparam logic [11:0] C_OVER  = 12'h789;
  localparam logic [11:0] C_L0    = 12'hA0A;
  localparam logic [11:0] C_L1    = 12'hB0B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  game_flow_sequencer_if #(.NUM_LEVELS(NL), .NUM_LIVES(3), .COLOR_WIDTH(CW),
                           .LED_WIDTH(10)) bus ();

  game_flow_sequencer #(.NUM_LEVELS(NL), .NUM_LIVES(3), .COLOR_WIDTH(CW),
                        .SCREEN_HOLD_FRAMES(2), .LED_WIDTH(10)) dut (
    .vga_clock (clk),
    .reset     (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] vga();
    return {bus.vga_red, bus.vga_green, bus.vga_blue};
  endfunction

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press();
    bus.start_button = 1'b0;
    tick();
    bus.start_button = 1'b1;
    tick();
  endtask

  task automatic frame();
    bus.frame_tick = 1'b1;
    tick();
    bus.frame_tick = 1'b0;
    tick();
  endtask

  // Two frame ticks then the exit cycle: the DUT is in PLAY on return.
  task automatic enter_play();
    frame();
    frame();
  endtask

  task automatic test_reset();
    tick(3);
    n_tests++;
    if (vga() !== 12'h000) begin n_fail++; $display("FAIL reset_vga got %h want 000", vga()); end
    n_tests++;
    if (bus.level_reset !== 2'b11 || bus.level_enable !== 2'b00) begin
      n_fail++; $display("FAIL reset_levels got rst=%b en=%b want 11/00", bus.level_reset, bus.level_enable);
    end
    n_tests++;
    if (bus.lives !== 2'd3 || bus.current_level !== 1'b0 || bus.leds !== 10'b0000000111) begin
      n_fail++; $display("FAIL reset_lives got lives=%0d lvl=%0d leds=%b want 3/0/0000000111",
                         bus.lives, bus.current_level, bus.leds);
    end
    rst = 1'b0;
    tick(100);
    n_tests++;
    if (vga() !== C_START) begin n_fail++; $display("FAIL start_screen got %h want %h", vga(), C_START); end
    bus.display_enable = 1'b0;
    tick();
    n_tests++;
    if (vga() !== 12'h000) begin n_fail++; $display("FAIL blanking got %h want 000", vga()); end
    bus.display_enable = 1'b1;
    tick();
  endtask

  task automatic test_inter();
    press();
    n_tests++;
    if (vga() !== 12'h000 || bus.level_enable !== 2'b00 || bus.level_reset !== 2'b11) begin
      n_fail++; $display("FAIL inter_black got vga=%h en=%b rst=%b want 000/00/11", vga(), bus.level_enable, bus.level_reset);
    end
    frame();
    tick(3);
    bus.frame_tick = 1'b1;
    tick();
    bus.frame_tick = 1'b0;
    n_tests++;
    if (bus.level_enable !== 2'b00) begin n_fail++; $display("FAIL inter_hold got en=%b want 00", bus.level_enable); end
    tick();
    n_tests++;
    if (bus.level_enable !== 2'b01 || bus.level_reset !== 2'b10) begin
      n_fail++; $display("FAIL play_enter got en=%b rst=%b want 01/10", bus.level_enable, bus.level_reset);
    end
    tick();
    n_tests++;
    if (vga() !== C_L0) begin n_fail++; $display("FAIL play_colour got %h want %h", vga(), C_L0); end
  endtask

  task automatic test_win_path();
    bus.level_win = 2'b01;
    tick();
    bus.level_win = 2'b00;
    n_tests++;
    if (bus.current_level !== 1'b1 || bus.level_enable !== 2'b00 || bus.level_reset !== 2'b11) begin
      n_fail++; $display("FAIL win_next got lvl=%0d en=%b rst=%b want 1/00/11", bus.current_level, bus.level_enable, bus.level_reset);
    end
    enter_play();
    n_tests++;
    if (bus.level_enable !== 2'b10) begin n_fail++; $display("FAIL play_l1 got en=%b want 10", bus.level_enable); end
    tick();
    n_tests++;
    if (vga() !== C_L1) begin n_fail++; $display("FAIL l1_colour got %h want %h", vga(), C_L1); end
    bus.level_win = 2'b10;
    tick();
    bus.level_win = 2'b00;
    tick();
    n_tests++;
    if (vga() !== C_WIN || bus.lives !== 2'd3 || bus.level_enable !== 2'b00) begin
      n_fail++; $display("FAIL win_screen got vga=%h lives=%0d en=%b want %h/3/00", vga(), bus.lives, bus.level_enable, C_WIN);
    end
    press();
    tick();
    n_tests++;
    if (vga() !== C_START || bus.current_level !== 1'b0) begin
      n_fail++; $display("FAIL win_to_start got vga=%h lvl=%0d want %h/0", vga(), bus.current_level, C_START);
    end
  endtask

  task automatic test_lose_path();
    logic [1:0]  exp_lives [3] = '{2'd2, 2'd1, 2'd0};
    logic [9:0]  exp_leds  [3] = '{10'b11, 10'b1, 10'b0};
    press();
    for (int k = 0; k < 3; k++) begin
      enter_play();
      bus.level_lose = 2'b01;
      tick();
      bus.level_lose = 2'b00;
      n_tests++;
      if (bus.lives !== exp_lives[k] || bus.leds !== exp_leds[k] || bus.current_level !== 1'b0 ||
          bus.level_reset !== 2'b11) begin
        n_fail++; $display("FAIL lose_%0d got lives=%0d leds=%b lvl=%0d rst=%b want %0d/%b/0/11",
                           k, bus.lives, bus.leds, bus.current_level, bus.level_reset, exp_lives[k], exp_leds[k]);
      end
    end
    tick(6);
    n_tests++;
    if (vga() !== C_OVER || bus.level_enable !== 2'b00) begin
      n_fail++; $display("FAIL over_screen got vga=%h en=%b want %h/00", vga(), bus.level_enable, C_OVER);
    end
    press();
    n_tests++;
    if (bus.lives !== 2'd3 || bus.leds !== 10'b111) begin
      n_fail++; $display("FAIL over_restart got lives=%0d leds=%b want 3/0000000111", bus.lives, bus.leds);
    end
  endtask

  task automatic test_priority();
    press();
    enter_play();
    bus.level_win = 2'b10;
    bus.level_lose = 2'b10;
    tick();
    bus.level_win = 2'b00;
    bus.level_lose = 2'b00;
    n_tests++;
    if (bus.level_enable !== 2'b01 || bus.current_level !== 1'b0 || bus.lives !== 2'd3) begin
      n_fail++; $display("FAIL other_level_ignored got en=%b lvl=%0d lives=%0d want 01/0/3", bus.level_enable, bus.current_level, bus.lives);
    end
    bus.level_win = 2'b01;
    bus.level_lose = 2'b01;
    tick();
    bus.level_win = 2'b00;
    bus.level_lose = 2'b00;
    n_tests++;
    if (bus.current_level !== 1'b1 || bus.lives !== 2'd3 || bus.level_enable !== 2'b00) begin
      n_fail++; $display("FAIL win_priority got lvl=%0d lives=%0d en=%b want 1/3/00", bus.current_level, bus.lives, bus.level_enable);
    end
    enter_play();
  endtask

  task automatic test_button_hold_and_reset();
    bus.start_button = 1'b0;
    tick(3);
    bus.level_win = 2'b10;
    tick();
    bus.level_win = 2'b00;
    tick(5);
    n_tests++;
    if (vga() !== C_WIN) begin n_fail++; $display("FAIL held_button got %h want %h", vga(), C_WIN); end
    bus.start_button = 1'b1;
    tick(3);
    n_tests++;
    if (vga() !== C_WIN) begin n_fail++; $display("FAIL release_only got %h want %h", vga(), C_WIN); end
    press();
    n_tests++;
    if (vga() !== C_START) begin n_fail++; $display("FAIL release_press got %h want %h", vga(), C_START); end
    press();
    enter_play();
    bus.level_lose = 2'b01;
    tick();
    bus.level_lose = 2'b00;
    enter_play();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (bus.lives !== 2'd3 || bus.level_enable !== 2'b00 || bus.level_reset !== 2'b11 || bus.current_level !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got lives=%0d en=%b rst=%b lvl=%0d want 3/00/11/0",
                         bus.lives, bus.level_enable, bus.level_reset, bus.current_level);
    end
    tick();
    n_tests++;
    if (vga() !== C_START) begin n_fail++; $display("FAIL mid_reset_start got %h want %h", vga(), C_START); end
  endtask

  initial begin
    bus.start_button   = 1'b1;
    bus.frame_tick     = 1'b0;
    bus.display_enable = 1'b1;
    bus.level_win      = '0;
    bus.level_lose     = '0;
    bus.level_rgb      = {C_L1, C_L0};
    bus.start_rgb      = C_START;
    bus.win_rgb        = C_WIN;
    bus.over_rgb       = C_OVER;
    test_reset();
    test_inter();
    test_win_path();
    test_lose_path();
    test_priority();
    test_button_hold_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
